rng3_lfsr_core: RTL and testbench
=================================

Name: rng3_lfsr_core

Overview:
- Pseudo-random byte generator in the standard 8-in/8-out/8-bidir user-tile shell.
- Core: 32-bit maximal-length Fibonacci LFSR, with these functions:
  - free-run or single-step advance;
  - byte-wise seed loading through uio_in;
  - optional whitened output;
  - optional drive of a second random byte onto uio.
- Sits directly under the tile top as the only user logic.

Parameters:
- SEED, 32'hACE1_2024, reset and lock-up recovery value of the LFSR (must be nonzero).
- WIDTH, 32, LFSR width (fixed; taps below are valid for 32 only).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  tile enable; 0 freezes all state (no step, no load, edge detector not updated).
- ui_in  in  8  control:
  - [0] run: advance LFSR every cycle;
  - [1] load strobe;
  - [3:2] seed byte select;
  - [4] uio drive enable;
  - [5] whiten select;
  - [6] step request (rising edge = one advance);
  - [7] reserved, ignored.
- uio_in  in  8  seed data byte.
- uo_out  out  8  random byte.
- uio_out  out  8  state[15:8] when ui_in[4]=1, else 8'h00.
- uio_oe  out  8  8'hFF when ui_in[4]=1, else 8'h00.

Behaviour:
- State: 32-bit register s, plus 1-bit step_d holding the previous ui_in[6]. All updates on rising clk.
- Reset (rst=1, synchronous, overrides ena):
  - s=SEED, step_d=0.
  - Outputs are combinational from s and ui_in, so after reset with ui_in=0: uo_out=8'h24, uio_out=0, uio_oe=0.
- Feedback: fb = s[31]^s[21]^s[1]^s[0] (x^32+x^22+x^2+x+1).
- Step: s_next = {s[30:0], fb}. If s==0 at a step, s_next=SEED instead (lock-up recovery).
- step_pulse = ui_in[6] & ~step_d; step_d <= ui_in[6] whenever ena=1.
- advance = ui_in[0] | step_pulse. Run and pulse in the same cycle produce exactly one advance.
- Load, when ui_in[1]=1 (level-sensitive; repeats every cycle while held): s[8*k+7:8*k] <= uio_in with k=ui_in[3:2]; other bytes unchanged.
- Priority: rst > load > advance. Load in the same cycle as advance means load only, no shift.
- Loading an all-zero state is allowed; the next advance restores SEED.
- ena=0: s and step_d hold. Outputs still reflect s and live ui_in.
- uo_out = ui_in[5] ? (s[7:0]^s[31:24]) : s[7:0]. Combinational, zero-cycle latency from the s register.
- Period: 2^32-1 advances, never visiting 0 unless zero is loaded.

Decomposition:
- Package rng3_pkg: SEED constant, tap positions, ui_in bit-index constants (RUN, LOAD, BSEL_LO/HI, UIO_EN, WHITEN, STEP).
- One natural sub-module, lfsr32_step: pure combinational next-state function including zero recovery.
- Top holds registers, control decode and output muxing.

Test Plan:
- Reset, then ui_in=0:
  - uo_out=8'h24, uio_oe=8'h00, uio_out=8'h00;
  - hold 5 cycles with ui_in=0 -> value unchanged.
- ui_in=8'h01 for 1 cycle -> s=32'h59C2_4048, uo_out=8'h48.
  - Then ui_in=8'h21 -> uo_out = next s[7:0]^s[31:24].
- ui_in[6] held high 4 cycles from low -> exactly one advance: uo_out 8'h24 -> 8'h48.
  - Repeat with ena=0 -> no change.
- Load with uio_in=8'h5A and ui_in=8'h03 (load+run, byte 0) -> s=32'hACE1_205A, no shift.
  - ui_in=8'h0E, uio_in=8'hC3 -> s[31:24]=8'hC3.
- Load zero into all four bytes, then one run cycle -> s=SEED, uo_out=8'h24.
- ui_in[4]=1 after reset -> uio_oe=8'hFF, uio_out=8'h20.
  - Assert rst mid-run -> next edge s=SEED regardless of ui_in.

Source files
------------

// File: rtl/rng3_pkg.sv
// rng3_pkg: shared constants for the rng3 LFSR core
package rng3_pkg;
    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;
    localparam int RUN = 0;
    localparam int LOAD = 1;
    localparam int BSEL_LO = 2;
    localparam int BSEL_HI = 3;
    localparam int UIO_EN = 4;
    localparam int WHITEN = 5;
    localparam int STEP = 6;
endpackage

// File: rtl/rng3_lfsr_core_if.sv
// rng3_lfsr_core_if: tile-shell signal bundle between the harness and the core
interface rng3_lfsr_core_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/lfsr32_step.sv
// lfsr32_step: one Fibonacci LFSR advance, with all-zero state recovering to SEED
module lfsr32_step
    import rng3_pkg::*;
#(
    parameter logic [31:0] RSEED = rng3_pkg::SEED
) (
    input  logic [31:0] s_i,
    output logic [31:0] s_o
);
    assign s_o = (s_i == 32'h0) ? RSEED : {s_i[30:0], s_i[TAP_A] ^ s_i[TAP_B] ^ s_i[TAP_C] ^ s_i[TAP_D]};
endmodule

// File: rtl/rng3_lfsr_core.sv
// rng3_lfsr_core: 32-bit LFSR byte generator with seed load, whitening and uio drive
module rng3_lfsr_core
    import rng3_pkg::*;
#(
    parameter logic [31:0] SEED = rng3_pkg::SEED,
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    rng3_lfsr_core_if.slave bus
);
    logic [WIDTH-1:0] s_q, s_d, s_step, s_ld;
    logic stp_q;
    logic adv;
    lfsr32_step #(.RSEED(SEED)) u_step (.s_i(s_q), .s_o(s_step));
    // next state: load beats advance; a step request counts only on its rising edge
    always_comb begin
        s_ld = s_q;
        s_ld[8*bus.ui_in[BSEL_HI:BSEL_LO] +: 8] = bus.uio_in;
        adv = bus.ui_in[RUN] | (bus.ui_in[STEP] & ~stp_q);
        s_d = bus.ui_in[LOAD] ? s_ld : adv ? s_step : s_q;
    end
    // state registers; reset overrides ena, ena=0 freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= SEED;
            stp_q <= 1'b0;
        end else if (bus.ena) begin
            s_q <= s_d;
            stp_q <= bus.ui_in[STEP];
        end
    end
    // outputs are combinational from the state and the live control byte
    always_comb begin
        bus.uo_out = bus.ui_in[WHITEN] ? (s_q[7:0] ^ s_q[31:24]) : s_q[7:0];
        bus.uio_out = bus.ui_in[UIO_EN] ? s_q[15:8] : 8'h00;
        bus.uio_oe = {8{bus.ui_in[UIO_EN]}};
    end
endmodule

// File: tb/tb_rng3_lfsr_core.sv
// tb_rng3_lfsr_core: scoreboard bench for the rng3 LFSR core
module tb_rng3_lfsr_core;
    logic clk;
    logic rst;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ms;
    logic ms_stp;
    logic [23:0] exp_q[$];
    rng3_lfsr_core_if bif ();
    rng3_lfsr_core dut (.clk(clk), .rst(rst), .bus(bif));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] nxt(input logic [31:0] s);
        if (s == 32'h0) return 32'hACE1_2024;
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic r, input logic e, input logic [7:0] u, input logic [7:0] d);
        logic [23:0] x;
        rst = r;
        bif.ena = e;
        bif.ui_in = u;
        bif.uio_in = d;
        if (r) begin
            ms = 32'hACE1_2024;
            ms_stp = 1'b0;
        end else if (e) begin
            if (u[1]) ms[8*u[3:2] +: 8] = d;
            else if (u[0] | (u[6] & ~ms_stp)) ms = nxt(ms);
            ms_stp = u[6];
        end
        exp_q.push_back({u[5] ? (ms[7:0] ^ ms[31:24]) : ms[7:0], u[4] ? ms[15:8] : 8'h00, {8{u[4]}}});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("uo_out", {24'h0, bif.uo_out}, {24'h0, x[23:16]});
        chk("uio_out", {24'h0, bif.uio_out}, {24'h0, x[15:8]});
        chk("uio_oe", {24'h0, bif.uio_oe}, {24'h0, x[7:0]});
    endtask
    initial begin
        ms = 32'h0;
        ms_stp = 1'b0;
        cyc(1, 1, 8'h00, 8'h00);
        chk("reset_uo", {24'h0, bif.uo_out}, 32'h24);
        chk("reset_oe", {24'h0, bif.uio_oe}, 32'h00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, 8'h00);
        chk("hold_uo", {24'h0, bif.uo_out}, 32'h24);
        cyc(0, 1, 8'h01, 8'h00);
        chk("run1_uo", {24'h0, bif.uo_out}, 32'h48);
        chk("run1_model", ms, 32'h59C2_4048);
        cyc(0, 1, 8'h21, 8'h00);
        chk("whiten_uo", {24'h0, bif.uo_out}, 32'h23);
        cyc(1, 1, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h40, 8'h00);
        chk("step_once", {24'h0, bif.uo_out}, 32'h48);
        cyc(0, 1, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h40, 8'h00);
        chk("ena0_hold", {24'h0, bif.uo_out}, 32'h48);
        cyc(0, 0, 8'h01, 8'h00);
        chk("ena0_run", {24'h0, bif.uo_out}, 32'h48);
        cyc(1, 1, 8'h00, 8'h00);
        cyc(0, 1, 8'h03, 8'h5A);
        chk("load_b0", {24'h0, bif.uo_out}, 32'h5A);
        cyc(0, 1, 8'h0E, 8'hC3);
        cyc(0, 0, 8'h20, 8'h00);
        chk("load_b3", {24'h0, bif.uo_out}, 32'h99);
        for (int k = 0; k < 4; k++) cyc(0, 1, 8'h02 | 8'(k << 2), 8'h00);
        chk("zero_uo", {24'h0, bif.uo_out}, 32'h00);
        cyc(0, 1, 8'h01, 8'h00);
        chk("recover_uo", {24'h0, bif.uo_out}, 32'h24);
        cyc(1, 1, 8'h00, 8'h00);
        cyc(0, 0, 8'h10, 8'h00);
        chk("uio_oe_on", {24'h0, bif.uio_oe}, 32'hFF);
        chk("uio_out_on", {24'h0, bif.uio_out}, 32'h20);
        for (int i = 0; i < 7; i++) cyc(0, 1, 8'h11, 8'h00);
        cyc(1, 1, 8'h43, 8'h77);
        chk("rst_mid", {24'h0, bif.uo_out}, 32'h24);
        for (int i = 0; i < 400; i++) begin
            logic [7:0] u;
            u = 8'($urandom);
            if (u[1] && $urandom_range(0, 3) != 0) u[1] = 1'b0;
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0, u, 8'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
